// File: rtl/bolt_ir_barcode_core.sv
// IR/barcode open-drain LED sink driver with reference start-up FSM and mA level reporting.
// Optional BOLT_IR_SYNC_EN: adds an input synchroniser stage on the runtime enable/PWM inputs.
module bolt_ir_barcode_core #(
  parameter int STARTUP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       poc,
  input  logic       vccio,
  input  logic       drivergnd,
  input  logic       icc40u,
  input  logic       cbit_ir_en,
  input  logic       cbit_barcode_en,
  input  logic       cbit_rgb_en,
  input  logic       cbit_ir500,
  input  logic       cbit_ir_half_cur,
  input  logic [7:0] cbit_ir,
  input  logic [3:0] cbit_barcode,
  input  logic       irled_en,
  input  logic       ir_pwm,
  input  logic       barcode_en,
  input  logic       barcode_pwm,
  input  logic       rgbled_en,
  output logic       ir_pad,
  output logic       barcode_pad,
  output logic       i200uref,
  output logic [9:0] ir_level_ma,
  output logic [9:0] barcode_level_ma
);

  localparam int RAMP_LEN = (STARTUP_CYCLES < 1) ? 1 :
                            ((STARTUP_CYCLES > 255) ? 255 : STARTUP_CYCLES);
  localparam logic [7:0] RAMP_LAST = 8'(RAMP_LEN - 1);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_RAMP,
    ST_READY
  } ref_state_t;

  ref_state_t state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;

  logic       kill;
  logic       ready;
  logic       irled_en_s, ir_pwm_s, barcode_en_s, barcode_pwm_s, rgbled_en_s;

  logic       ir_sink_reg, ir_sink_next;
  logic       bc_sink_reg, bc_sink_next;
  logic       i200_reg, i200_next;
  logic [9:0] ir_ma_reg, ir_ma_next;
  logic [9:0] bc_ma_reg, bc_ma_next;

  logic [16:0] ir_prod;
  logic [8:0]  ir_ma_full;
  logic [9:0]  ir_ma;
  logic [6:0]  bc_prod;
  logic [9:0]  bc_ma;

  assign kill  = poc | icc40u | ~vccio | drivergnd;
  assign ready = (state_reg == ST_READY);

`ifdef BOLT_IR_SYNC_EN
  // First stage here; the output register acts as the second stage of the synchroniser.
  logic [4:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {irled_en, ir_pwm, barcode_en, barcode_pwm, rgbled_en};
    end
  end

  assign {irled_en_s, ir_pwm_s, barcode_en_s, barcode_pwm_s, rgbled_en_s} = sync_reg;
`else
  assign {irled_en_s, ir_pwm_s, barcode_en_s, barcode_pwm_s, rgbled_en_s} =
         {irled_en, ir_pwm, barcode_en, barcode_pwm, rgbled_en};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_OFF;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (kill) begin
      state_next = ST_OFF;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        ST_OFF: begin
          state_next = ST_RAMP;
          cnt_next   = '0;
        end
        ST_RAMP: begin
          cnt_next = cnt_reg + 8'd1;
          if (cnt_reg == RAMP_LAST) begin
            state_next = ST_READY;
          end
        end
        ST_READY: state_next = ST_READY;
        default: begin
          state_next = ST_OFF;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Full scale is 400 or 500 mA over a 256-step code; the low 8 product bits are dropped.
  assign ir_prod    = 17'(cbit_ir) * (cbit_ir500 ? 17'd500 : 17'd400);
  assign ir_ma_full = ir_prod[16:8];
  assign ir_ma      = cbit_ir_half_cur ? {2'b00, ir_ma_full[8:1]} : {1'b0, ir_ma_full};

  assign bc_prod = 7'(cbit_barcode) * 7'd6;
  assign bc_ma   = {3'b000, (bc_prod > 7'd90) ? 7'd90 : bc_prod};

  always_comb begin
    ir_sink_next = 1'b0;
    bc_sink_next = 1'b0;
    i200_next    = 1'b0;
    ir_ma_next   = '0;
    bc_ma_next   = '0;
    if (!kill && ready) begin
      ir_sink_next = cbit_ir_en & irled_en_s & ir_pwm_s & (cbit_ir != 8'd0);
      // In IR500 mode the barcode pad is ganged to IR and its current is reported on IR.
      if (cbit_ir500) begin
        bc_sink_next = ir_sink_next;
      end else begin
        bc_sink_next = cbit_barcode_en & barcode_en_s & barcode_pwm_s & (cbit_barcode != 4'd0);
        bc_ma_next   = bc_sink_next ? bc_ma : 10'd0;
      end
      ir_ma_next = ir_sink_next ? ir_ma : 10'd0;
      i200_next  = cbit_ir_en | cbit_barcode_en | (cbit_rgb_en & rgbled_en_s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_sink_reg <= 1'b0;
      bc_sink_reg <= 1'b0;
      i200_reg    <= 1'b0;
      ir_ma_reg   <= '0;
      bc_ma_reg   <= '0;
    end else begin
      ir_sink_reg <= ir_sink_next;
      bc_sink_reg <= bc_sink_next;
      i200_reg    <= i200_next;
      ir_ma_reg   <= ir_ma_next;
      bc_ma_reg   <= bc_ma_next;
    end
  end

  assign ir_pad           = ir_sink_reg ? 1'b0 : 1'bz;
  assign barcode_pad      = bc_sink_reg ? 1'b0 : 1'bz;
  assign i200uref         = i200_reg;
  assign ir_level_ma      = ir_ma_reg;
  assign barcode_level_ma = bc_ma_reg;

endmodule

// File: tb/tb_bolt_ir_barcode_core.sv
// Self-checking bench for bolt_ir_barcode_core (default build, STARTUP_CYCLES=16).
module tb_bolt_ir_barcode_core;

  localparam int SC = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       poc, vccio, drivergnd, icc40u;
  logic       cbit_ir_en, cbit_barcode_en, cbit_rgb_en, cbit_ir500, cbit_ir_half_cur;
  logic [7:0] cbit_ir;
  logic [3:0] cbit_barcode;
  logic       irled_en, ir_pwm, barcode_en, barcode_pwm, rgbled_en;
  wire        ir_pad, barcode_pad;
  logic       i200uref;
  logic [9:0] ir_level_ma, barcode_level_ma;

  // Open-drain pads: a released pad reads high through the board pull-up.
  pullup (ir_pad);
  pullup (barcode_pad);

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  bolt_ir_barcode_core #(.STARTUP_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .poc(poc), .vccio(vccio), .drivergnd(drivergnd),
    .icc40u(icc40u), .cbit_ir_en(cbit_ir_en), .cbit_barcode_en(cbit_barcode_en),
    .cbit_rgb_en(cbit_rgb_en), .cbit_ir500(cbit_ir500), .cbit_ir_half_cur(cbit_ir_half_cur),
    .cbit_ir(cbit_ir), .cbit_barcode(cbit_barcode), .irled_en(irled_en), .ir_pwm(ir_pwm),
    .barcode_en(barcode_en), .barcode_pwm(barcode_pwm), .rgbled_en(rgbled_en),
    .ir_pad(ir_pad), .barcode_pad(barcode_pad), .i200uref(i200uref),
    .ir_level_ma(ir_level_ma), .barcode_level_ma(barcode_level_ma)
  );

  typedef struct {
    logic [7:0] ir;
    logic       half;
    logic       ir500;
    logic [3:0] bc;
    logic       bc_pwm;
    logic       irp;
    logic       e_ir;
    logic       e_bc;
    int         e_irma;
    int         e_bcma;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic e_ir, input logic e_bc,
                       input int e_irma, input int e_bcma, input logic e_ref);
    logic ep_ir, ep_bc;
    ep_ir = e_ir ? 1'b0 : 1'b1;
    ep_bc = e_bc ? 1'b0 : 1'b1;
    tests++;
    if (ir_pad !== ep_ir || barcode_pad !== ep_bc || ir_level_ma !== 10'(e_irma) ||
        barcode_level_ma !== 10'(e_bcma) || i200uref !== e_ref) begin
      failed++;
      $display("FAIL %s: got ir_pad=%b bc_pad=%b ir_ma=%0d bc_ma=%0d ref=%b, need ir_pad=%b bc_pad=%b ir_ma=%0d bc_ma=%0d ref=%b",
               name, ir_pad, barcode_pad, ir_level_ma, barcode_level_ma, i200uref,
               ep_ir, ep_bc, e_irma, e_bcma, e_ref);
    end else begin
      $display("[TB] pass %s: ir_pad=%b bc_pad=%b ir_ma=%0d bc_ma=%0d ref=%b",
               name, ir_pad, barcode_pad, ir_level_ma, barcode_level_ma, i200uref);
    end
  endtask

  task automatic set_full();
    cbit_ir = 8'hFF; cbit_ir_half_cur = 1'b0; cbit_ir500 = 1'b0;
    cbit_barcode = 4'hF; barcode_pwm = 1'b1; ir_pwm = 1'b1;
  endtask

  // Fault on one kill source for a single edge, then expect a full fresh ramp.
  task automatic fault_recover(input int which, input string name);
    case (which)
      0: poc = 1'b1;
      1: vccio = 1'b0;
      default: drivergnd = 1'b1;
    endcase
    step();
    check(name, 1'b0, 1'b0, 0, 0, 1'b0);
    poc = 1'b0; vccio = 1'b1; drivergnd = 1'b0;
    for (int k = 1; k <= SC + 1; k++) begin
      step();
      if (k == 1 || k == SC + 1) check({name, "_ramp"}, 1'b0, 1'b0, 0, 0, 1'b0);
    end
    step();
    check({name, "_resume"}, 1'b1, 1'b1, 398, 90, 1'b1);
  endtask

  initial begin
    vecs[0]  = '{8'hFF, 1'b0, 1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 398, 90};
    vecs[1]  = '{8'hFF, 1'b1, 1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 199, 90};
    vecs[2]  = '{8'hFF, 1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 498, 0};
    vecs[3]  = '{8'hFF, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[4]  = '{8'hFF, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 498, 0};
    vecs[5]  = '{8'h00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
    vecs[6]  = '{8'h80, 1'b0, 1'b0, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 200, 0};
    vecs[7]  = '{8'h80, 1'b0, 1'b0, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1, 200, 30};
    vecs[8]  = '{8'h01, 1'b1, 1'b0, 4'h1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 6};
    vecs[9]  = '{8'h01, 1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 0};
    vecs[10] = '{8'h33, 1'b1, 1'b1, 4'h2, 1'b1, 1'b1, 1'b1, 1'b1, 49, 0};
    vecs[11] = '{8'h33, 1'b0, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 0, 12};

    rst_n = 1'b0;
    poc = 1'b0; vccio = 1'b1; drivergnd = 1'b0; icc40u = 1'b0;
    cbit_ir_en = 1'b1; cbit_barcode_en = 1'b1; cbit_rgb_en = 1'b1;
    irled_en = 1'b1; barcode_en = 1'b1; rgbled_en = 1'b1;
    set_full();
    #1;
    check("reset", 1'b0, 1'b0, 0, 0, 1'b0);
    step();
    step();
    rst_n = 1'b1;

    // Start-up: first edge after release is edge 0; READY at edge SC, outputs from SC+1.
    for (int e = 0; e <= SC + 3; e++) begin
      step();
      check($sformatf("startup_e%0d", e), e >= SC + 1, e >= SC + 1,
            (e >= SC + 1) ? 398 : 0, (e >= SC + 1) ? 90 : 0, e >= SC + 1);
    end

    for (int i = 0; i < 12; i++) begin
      cbit_ir = vecs[i].ir; cbit_ir_half_cur = vecs[i].half; cbit_ir500 = vecs[i].ir500;
      cbit_barcode = vecs[i].bc; barcode_pwm = vecs[i].bc_pwm; ir_pwm = vecs[i].irp;
      step();
      check($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_bc, vecs[i].e_irma, vecs[i].e_bcma, 1'b1);
    end

    // Both PWMs drop together, then recover together.
    set_full();
    step();
    ir_pwm = 1'b0; barcode_pwm = 1'b0;
    step();
    check("pwm_both_off", 1'b0, 1'b0, 0, 0, 1'b1);
    ir_pwm = 1'b1; barcode_pwm = 1'b1;
    step();
    check("pwm_both_on", 1'b1, 1'b1, 398, 90, 1'b1);

    fault_recover(0, "poc");
    fault_recover(1, "vccio");
    fault_recover(2, "drivergnd");

    // Mid-ramp kill restarts the count from zero.
    icc40u = 1'b1;
    step();
    icc40u = 1'b0;
    repeat (8) step();
    icc40u = 1'b1;
    step();
    icc40u = 1'b0;
    for (int k = 1; k <= SC + 2; k++) begin
      step();
      if (k >= SC) check($sformatf("restart_k%0d", k), k == SC + 2, k == SC + 2,
                         (k == SC + 2) ? 398 : 0, (k == SC + 2) ? 90 : 0, k == SC + 2);
    end

    // Asynchronous reset releases the pads between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 1'b0, 1'b0, 0, 0, 1'b0);
    step();
    rst_n = 1'b1;

    // Randomized run against a reference model: the reference is ready once
    // SC+1 consecutive edges have passed without any kill source active.
    begin
      int alive;
      int e_irma, e_bcma;
      logic kill_now, rdy, ir_on, bc_on, ref_on;
      alive = 0;
      for (int c = 0; c < 600; c++) begin
        poc       = ($urandom_range(0, 149) == 0);
        icc40u    = ($urandom_range(0, 149) == 0);
        vccio     = ($urandom_range(0, 149) != 0);
        drivergnd = ($urandom_range(0, 149) == 0);
        cbit_ir_en = $urandom_range(0, 3) != 0;
        cbit_barcode_en = $urandom_range(0, 3) != 0;
        cbit_rgb_en = 1'($urandom);
        cbit_ir500 = 1'($urandom);
        cbit_ir_half_cur = 1'($urandom);
        cbit_ir = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        cbit_barcode = 4'($urandom);
        irled_en = $urandom_range(0, 3) != 0;
        ir_pwm = 1'($urandom);
        barcode_en = $urandom_range(0, 3) != 0;
        barcode_pwm = 1'($urandom);
        rgbled_en = 1'($urandom);

        kill_now = poc || icc40u || !vccio || drivergnd;
        rdy = !kill_now && (alive >= SC + 1);
        ir_on = rdy && cbit_ir_en && irled_en && ir_pwm && (cbit_ir != 0);
        e_irma = ir_on ? ((int'(cbit_ir) * (cbit_ir500 ? 500 : 400)) / 256) / (cbit_ir_half_cur ? 2 : 1) : 0;
        if (cbit_ir500) begin
          bc_on = ir_on;
          e_bcma = 0;
        end else begin
          bc_on = rdy && cbit_barcode_en && barcode_en && barcode_pwm && (cbit_barcode != 0);
          e_bcma = bc_on ? ((int'(cbit_barcode) * 6 > 90) ? 90 : int'(cbit_barcode) * 6) : 0;
        end
        ref_on = rdy && (cbit_ir_en || cbit_barcode_en || (cbit_rgb_en && rgbled_en));
        alive = kill_now ? 0 : alive + 1;

        step();
        check($sformatf("rand%0d", c), ir_on, bc_on, e_irma, e_bcma, ref_on);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion before 200000");
    $fatal(1, "timeout");
  end

endmodule
